// File: rtl/gemm_tile_scheduler.sv
// Walks a GEMM of M x N x K over a ROWS x COLS core in row-major tile order,
// starting the core per tile and handing each finished tile to writeback.
module gemm_tile_scheduler #(
    parameter int ROWS    = 16,
    parameter int COLS    = 16,
    parameter int K_MAX   = 2048,
    parameter int DIM_W   = 16,
    parameter int TIMEOUT = 65536
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [DIM_W-1:0] cmd_m,
    input  logic [DIM_W-1:0] cmd_n,
    input  logic [DIM_W-1:0] cmd_k,
    output logic             core_start,
    input  logic             core_busy,
    input  logic             core_done,
    output logic [DIM_W-1:0] core_cfg_m,
    output logic [DIM_W-1:0] core_cfg_n,
    output logic [DIM_W-1:0] core_cfg_k,
    output logic [DIM_W-1:0] tile_row_base,
    output logic [DIM_W-1:0] tile_col_base,
    output logic             wb_valid,
    input  logic             wb_ready,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [DIM_W-1:0] tiles_done
);
    localparam int               TW       = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0]    TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [DIM_W:0]   ROWS_X   = (DIM_W+1)'(ROWS);
    localparam logic [DIM_W:0]   COLS_X   = (DIM_W+1)'(COLS);
    localparam logic [DIM_W-1:0] ROWS_D   = DIM_W'(ROWS);
    localparam logic [DIM_W-1:0] COLS_D   = DIM_W'(COLS);
    localparam logic [31:0]      K_MAX_U  = 32'(K_MAX);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_DONE, WRITEBACK, FINISH} state_t;

    state_t           state_reg, state_next;
    logic [DIM_W-1:0] m_reg, n_reg, k_reg;
    logic [DIM_W:0]   row_base_reg, col_base_reg;
    logic [TW-1:0]    tmo_cnt_reg;
    logic [DIM_W-1:0] tiles_done_reg;
    logic             err_reg;

    logic             cmd_bad, col_wrap, last_tile;
    logic [DIM_W:0]   row_adv, col_adv;
    logic [DIM_W-1:0] rem_m, rem_n;

    // The core's own busy flag carries no information the done pulse lacks.
    logic unused_core_busy;
    assign unused_core_busy = core_busy;

    assign cmd_bad   = (cmd_m == '0) || (cmd_n == '0) || (cmd_k == '0) ||
                       (32'(cmd_k) > K_MAX_U);
    assign row_adv   = row_base_reg + ROWS_X;
    assign col_adv   = col_base_reg + COLS_X;
    assign col_wrap  = (col_adv >= {1'b0, n_reg});
    assign last_tile = col_wrap && (row_adv >= {1'b0, m_reg});

    assign tile_row_base = row_base_reg[DIM_W-1:0];
    assign tile_col_base = col_base_reg[DIM_W-1:0];
    assign rem_m         = m_reg - tile_row_base;
    assign rem_n         = n_reg - tile_col_base;
    assign core_cfg_m    = (rem_m < ROWS_D) ? rem_m : ROWS_D;
    assign core_cfg_n    = (rem_n < COLS_D) ? rem_n : COLS_D;
    assign core_cfg_k    = k_reg;
    assign tiles_done    = tiles_done_reg;
    assign busy          = (state_reg != IDLE);

    always_comb begin
        state_next = state_reg;
        cmd_ready  = 1'b0;
        core_start = 1'b0;
        wb_valid   = 1'b0;
        done       = 1'b0;
        err        = 1'b0;
        case (state_reg)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid)
                    state_next = cmd_bad ? FINISH : ISSUE;
            end
            ISSUE: begin
                core_start = 1'b1;
                state_next = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (core_done)
                    state_next = WRITEBACK;
                else if (tmo_cnt_reg == TMO_LAST)
                    state_next = FINISH;
            end
            WRITEBACK: begin
                wb_valid = 1'b1;
                if (wb_ready)
                    state_next = last_tile ? FINISH : ISSUE;
            end
            FINISH: begin
                done       = 1'b1;
                err        = err_reg;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            m_reg          <= '0;
            n_reg          <= '0;
            k_reg          <= '0;
            row_base_reg   <= '0;
            col_base_reg   <= '0;
            tmo_cnt_reg    <= '0;
            tiles_done_reg <= '0;
            err_reg        <= 1'b0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (cmd_valid) begin
                        m_reg          <= cmd_m;
                        n_reg          <= cmd_n;
                        k_reg          <= cmd_k;
                        row_base_reg   <= '0;
                        col_base_reg   <= '0;
                        tiles_done_reg <= '0;
                        err_reg        <= cmd_bad;
                    end
                end
                ISSUE: tmo_cnt_reg <= '0;
                WAIT_DONE: begin
                    if (!core_done) begin
                        tmo_cnt_reg <= tmo_cnt_reg + TW'(1);
                        if (tmo_cnt_reg == TMO_LAST)
                            err_reg <= 1'b1;
                    end
                end
                WRITEBACK: begin
                    // Bases only move on the handshake so they stay put while wb is stalled.
                    if (wb_ready) begin
                        tiles_done_reg <= tiles_done_reg + DIM_W'(1);
                        if (!last_tile) begin
                            if (col_wrap) begin
                                col_base_reg <= '0;
                                row_base_reg <= row_adv;
                            end else begin
                                col_base_reg <= col_adv;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_gemm_tile_scheduler.sv
// Bench for gemm_tile_scheduler: a tile-list model built from M/N/K checks every
// start, writeback and done, plus literal expectations for the directed cases.
module tb_gemm_tile_scheduler;
    localparam int ROWS = 16, COLS = 16, K_MAX = 2048, DIM_W = 16, TIMEOUT = 32;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [DIM_W-1:0] cmd_m = '0, cmd_n = '0, cmd_k = '0;
    logic             core_start, core_busy = 1'b0, core_done = 1'b0;
    logic [DIM_W-1:0] core_cfg_m, core_cfg_n, core_cfg_k;
    logic [DIM_W-1:0] tile_row_base, tile_col_base, tiles_done;
    logic             wb_valid, wb_ready = 1'b0;
    logic             busy, done, err;

    gemm_tile_scheduler #(.ROWS(ROWS), .COLS(COLS), .K_MAX(K_MAX), .DIM_W(DIM_W),
                          .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_m(cmd_m), .cmd_n(cmd_n), .cmd_k(cmd_k),
        .core_start(core_start), .core_busy(core_busy), .core_done(core_done),
        .core_cfg_m(core_cfg_m), .core_cfg_n(core_cfg_n), .core_cfg_k(core_cfg_k),
        .tile_row_base(tile_row_base), .tile_col_base(tile_col_base),
        .wb_valid(wb_valid), .wb_ready(wb_ready),
        .busy(busy), .done(done), .err(err), .tiles_done(tiles_done)
    );

    always #5 clk = ~clk;

    typedef struct {int r; int c; int cm; int cn; int k;} tile_t;

    int    checks = 0, errors = 0;
    tile_t exp_q[$];
    tile_t obs_q[$];
    tile_t cur;
    bit    exp_busy = 0, exp_err = 0, cur_wb = 1;
    int    model_tiles = 0, exp_done_cyc = 0, cyc = 0;
    int    starts = 0, done_seen = 0, last_err = 0;
    int    last_start_cyc = 0, last_done_cyc = 0;
    int    core_lat = 3, core_cnt = 0, wb_stall = 0, wb_wait = 0;
    int    wbv_cnt = 0, last_wb_len = 0;
    bit    hang = 0, last_wb_valid = 0;
    int    acc_m = 0, acc_n = 0, acc_k = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic void build_expect(input int m, input int n, input int k);
        tile_t t;
        exp_q.delete();
        exp_err = (m == 0) || (n == 0) || (k == 0) || (k > K_MAX);
        if (!exp_err)
            for (int r = 0; r < m; r += ROWS)
                for (int c = 0; c < n; c += COLS) begin
                    t.r  = r;
                    t.c  = c;
                    t.cm = (m - r < ROWS) ? m - r : ROWS;
                    t.cn = (n - c < COLS) ? n - c : COLS;
                    t.k  = k;
                    exp_q.push_back(t);
                end
    endfunction

    // Compare process plus core / writeback responders, all on the falling edge.
    always @(negedge clk) begin : mon
        tile_t t;
        bit    hs;
        cyc++;
        if (rst) begin
            exp_q.delete();
            exp_busy = 0; exp_done_cyc = 0; model_tiles = 0; cur_wb = 1;
            core_cnt = 0; core_done = 0; core_busy = 0;
            wb_ready = 0; wb_wait = 0; wbv_cnt = 0; last_wb_valid = 0;
        end else begin
            hs = last_wb_valid && wb_ready;
            chk("busy", busy, exp_busy);
            chk("cmd_ready", cmd_ready, !exp_busy);
            if (hs) begin
                model_tiles++;
                cur_wb = 1;
                last_wb_len = wbv_cnt;
                wbv_cnt = 0;
                if (exp_q.size() == 0) chk("done_after_last_wb", done, 1);
                else                   chk("start_after_wb", core_start, 1);
            end
            chk("tiles_done", tiles_done, model_tiles);
            if (core_start) begin
                chk("start_expected", (exp_q.size() != 0) && cur_wb, 1);
                if (exp_q.size() != 0) begin
                    t = exp_q.pop_front();
                    chk("cfg_m", core_cfg_m, t.cm);
                    chk("cfg_n", core_cfg_n, t.cn);
                    chk("cfg_k", core_cfg_k, t.k);
                    chk("row_base", tile_row_base, t.r);
                    chk("col_base", tile_col_base, t.c);
                    cur = t;
                end
                t.r = tile_row_base; t.c = tile_col_base;
                t.cm = core_cfg_m; t.cn = core_cfg_n; t.k = core_cfg_k;
                obs_q.push_back(t);
                cur_wb = 0;
                starts++;
                last_start_cyc = cyc;
                if (hang) exp_done_cyc = cyc + TIMEOUT + 1;
                else      core_cnt = core_lat;
            end
            if (wb_valid) begin
                wbv_cnt++;
                chk("wb_expected", !cur_wb, 1);
                chk("wb_row_base", tile_row_base, cur.r);
                chk("wb_col_base", tile_col_base, cur.c);
                chk("wb_cfg_m", core_cfg_m, cur.cm);
                chk("wb_cfg_n", core_cfg_n, cur.cn);
            end
            if (done) begin
                chk("done_expected", exp_busy, 1);
                chk("err", err, exp_err);
                if (exp_done_cyc != 0) chk("done_cycle", cyc, exp_done_cyc);
                if (!exp_err) chk("tiles_left", exp_q.size(), 0);
                $display("cmd M=%0d N=%0d K=%0d -> done err=%0d tiles_done=%0d starts=%0d",
                         acc_m, acc_n, acc_k, err, tiles_done, starts);
                last_err = err;
                last_done_cyc = cyc;
                done_seen++;
                exp_busy = 0; exp_done_cyc = 0; core_cnt = 0;
                exp_q.delete();
            end
            core_done = 0;
            if (core_cnt > 0) begin
                core_cnt--;
                if (core_cnt == 0) core_done = 1;
            end
            core_busy = (core_cnt > 0);
            if (wb_ready) begin
                wb_ready = 0;
                wb_wait = 0;
            end else if (wb_valid) begin
                if (wb_wait >= wb_stall) wb_ready = 1;
                else                     wb_wait++;
            end
            last_wb_valid = wb_valid;
            if (cmd_valid && cmd_ready) begin
                acc_m = cmd_m; acc_n = cmd_n; acc_k = cmd_k;
                build_expect(cmd_m, cmd_n, cmd_k);
                exp_done_cyc = exp_err ? cyc + 1 : 0;
                if (hang) exp_err = 1;
                model_tiles = 0;
                cur_wb = 1;
                exp_busy = 1;
            end
        end
    end

    task automatic send_cmd(input int m, input int n, input int k);
        @(posedge clk); #1;
        cmd_m = DIM_W'(m); cmd_n = DIM_W'(n); cmd_k = DIM_W'(k);
        cmd_valid = 1;
        @(posedge clk); #1;
        cmd_valid = 0;
    endtask

    task automatic run_cmd(input int m, input int n, input int k);
        int d0, i;
        d0 = done_seen;
        send_cmd(m, n, k);
        i = 0;
        while (done_seen == d0 && i < 3000) begin
            @(posedge clk);
            i++;
        end
        if (done_seen == d0) chk("done_timeout", 0, 1);
        @(negedge clk);
    endtask

    int s0, d0, i;
    int er [6] = '{0, 0, 16, 16, 32, 32};
    int ec [6] = '{0, 16, 0, 16, 0, 16};
    int ecm[6] = '{16, 16, 16, 16, 8, 8};
    int ecn[6] = '{16, 4, 16, 4, 16, 4};

    initial begin
        rst = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_core_start", core_start, 0);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_tiles_done", tiles_done, 0);
        chk("rst_cfg_m", core_cfg_m, 0);
        chk("rst_row_base", tile_row_base, 0);
        @(posedge clk); #1 rst = 0;

        // Single tile
        s0 = starts;
        run_cmd(16, 16, 64);
        chk("t1_starts", starts - s0, 1);
        chk("t1_cfg_m", obs_q[s0].cm, 16);
        chk("t1_cfg_n", obs_q[s0].cn, 16);
        chk("t1_cfg_k", obs_q[s0].k, 64);
        chk("t1_base", {obs_q[s0].r, obs_q[s0].c}, 0);
        chk("t1_err", last_err, 0);
        chk("t1_tiles_done", tiles_done, 1);

        // 3x2 tiles with ragged edges
        s0 = starts;
        run_cmd(40, 20, 8);
        chk("t2_starts", starts - s0, 6);
        for (int j = 0; j < 6; j++) begin
            chk("t2_row", obs_q[s0+j].r, er[j]);
            chk("t2_col", obs_q[s0+j].c, ec[j]);
            chk("t2_cfg_m", obs_q[s0+j].cm, ecm[j]);
            chk("t2_cfg_n", obs_q[s0+j].cn, ecn[j]);
        end
        chk("t2_tiles_done", tiles_done, 6);

        // Rejected commands and the K_MAX boundary
        s0 = starts;
        run_cmd(16, 16, 2049);
        chk("t3_kbig_err", last_err, 1);
        run_cmd(0, 16, 8);
        chk("t3_m0_err", last_err, 1);
        run_cmd(16, 0, 8);
        chk("t3_n0_err", last_err, 1);
        run_cmd(16, 16, 0);
        chk("t3_k0_err", last_err, 1);
        chk("t3_no_starts", starts - s0, 0);
        chk("t3_tiles_done", tiles_done, 0);
        run_cmd(17, 33, 2048);
        chk("t3_kmax_err", last_err, 0);
        chk("t3_kmax_starts", starts - s0, 6);
        chk("t3_last_cfg", {obs_q[s0+5].cm, obs_q[s0+5].cn}, {32'd1, 32'd1});
        chk("t3_last_base", {obs_q[s0+5].r, obs_q[s0+5].c}, {32'd16, 32'd32});

        // Writeback back-pressure
        wb_stall = 5;
        run_cmd(32, 32, 4);
        chk("t4_wb_len", last_wb_len, 6);
        chk("t4_tiles_done", tiles_done, 4);
        wb_stall = 0;

        // Core never finishes
        hang = 1;
        run_cmd(16, 16, 1);
        chk("t5_err", last_err, 1);
        chk("t5_timeout_len", last_done_cyc - last_start_cyc, TIMEOUT + 1);
        chk("t5_cmd_ready", cmd_ready, 1);
        hang = 0;

        // Reset during the third tile, then a clean rerun
        s0 = starts; d0 = done_seen; core_lat = 6;
        send_cmd(40, 20, 8);
        i = 0;
        while (starts < s0 + 3 && i < 500) begin
            @(posedge clk);
            i++;
        end
        chk("t6_third_tile", starts - s0, 3);
        repeat (2) @(posedge clk);
        #1 rst = 1;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk("t6_cmd_ready", cmd_ready, 1);
        chk("t6_busy", busy, 0);
        chk("t6_tiles_done", tiles_done, 0);
        repeat (10) @(negedge clk);
        chk("t6_no_done", done_seen - d0, 0);
        chk("t6_no_start", starts - s0, 3);
        core_lat = 3;
        s0 = starts;
        run_cmd(40, 20, 8);
        chk("t6_rerun_starts", starts - s0, 6);
        chk("t6_rerun_tiles", tiles_done, 6);
        chk("t6_rerun_err", last_err, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end
endmodule
